sdf_stage_ctrl: RTL and testbench
=================================

Name: sdf_stage_ctrl

Overview:
- Sequencing controller for one radix-2 single-path delay-feedback (SDF) FFT stage.
- Drives the stage's delay-line shift register (advance enable, zero-fill), the butterfly/pass-through select and the twiddle ROM address.
- Tracks sample index within a frame and gates output valid and start-of-frame.
- Sits between the stream source and the stage datapath; one instance per stage.

Parameters:
- N_FFT, 64, transform size (power of 2, >= 4).
- STAGE, 0, stage index, 0 .. log2(N_FFT)-1.
- DELAY, N_FFT>>(STAGE+1), delay-line depth; derived, not overridden.
- LOG2N, $clog2(N_FFT), derived.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample present.
- in_sof  in  1  first sample of a frame; qualified by in_valid.
- flush  in  1  request drain of delay line after the final frame.
- in_ready  out  1  controller accepts input this cycle.
- sr_en  out  1  advance delay line.
- zero_in  out  1  datapath substitutes 0 for the input sample (drain).
- bf_sel  out  1  0 = fill/pass-through, 1 = butterfly.
- tw_addr  out  LOG2N-1  twiddle ROM index.
- tw_en  out  1  twiddle multiply active on delay-line output.
- out_valid  out  1  stage output valid (registered).
- out_sof  out  1  first output sample of a frame (registered).
- sof_err  out  1  one-cycle pulse when in_sof arrives with cnt != 0.
- busy  out  1  state != IDLE.

Behaviour:
- Decided interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: state = IDLE, cnt = 0, flush_pend = 0, drain_cnt = 0. All outputs 0, except in_ready = 1.
- cnt: log2(2*DELAY) bits, modulo 2*DELAY. It increments on every advance (adv = sr_en). phase = cnt MSB, k = cnt low bits.
- Accept condition: acc = in_valid & in_ready.
- sr_en = acc | (state == FLUSH).
- bf_sel = phase. zero_in = (state == FLUSH).
- Decodes (combinational from registered state/cnt, aligned with the sample presented this cycle):
  - tw_en = adv & ~phase & (state != FILL).
  - tw_addr = k << STAGE, width LOG2N-1; bits shifted out are dropped.
- States:
  - IDLE: on acc & in_sof, go to FILL, cnt = 1. acc without in_sof is ignored (no advance, sr_en = 0).
  - FILL: first DELAY samples of the first frame. Outputs not valid. When cnt reaches DELAY (phase 1), go to RUN.
  - RUN: every advance produces an output. out_valid <= adv one cycle later. out_sof <= adv & (cnt == DELAY) & first-output-of-frame.
  - FLUSH: in_ready = 0. Exactly DELAY advances with zero_in = 1, phase = 0, tw_en = 1, tw_addr = k<<STAGE, out_valid per advance. After the last advance go to IDLE, cnt = 0.
- Flush handling:
  - flush is sampled in RUN only. If cnt == 0, enter FLUSH next cycle.
  - Otherwise set flush_pend. Normal input continues; enter FLUSH when cnt wraps to 0.
  - flush in IDLE/FILL is ignored. In FILL the partial frame is discarded: go to IDLE, cnt = 0.
- Stalls: in_valid low holds cnt and state; sr_en = 0, out_valid = 0 next cycle.
- Resync: acc & in_sof with cnt != 0 in FILL or RUN gives sof_err = 1 for one cycle. The sample is taken as index 0 (cnt = 1) and state goes to FILL (delay-line contents stale). out_valid deasserts.
- acc & in_sof with cnt == 0 in RUN is normal.
- Simultaneous flush and in_sof at cnt == 0 in RUN: the sample is accepted; flush becomes pending.
- Reset mid-operation (any state): immediate return to reset values. Pending flush is lost.

Decomposition:
- Shared package fft_pkg: state encoding (IDLE/FILL/RUN/FLUSH) and the DELAY/LOG2N derivation functions, reused by all stage controllers.
- No sub-module; single flat controller. The datapath instantiates the existing delay-line register separately.

Test Plan:
- Reset (N_FFT=8, STAGE=0, DELAY=4): rst_n low mid-stream -> all outputs 0 and in_ready = 1 in the same cycle; busy = 0.
- Single frame: 8 back-to-back samples, in_sof on sample 0 -> bf_sel 0,0,0,0,1,1,1,1; out_valid high from the cycle after sample 4 through sample 7; out_sof with the first output.
- Two frames then flush at cnt == 0 -> 4 FLUSH cycles: in_ready = 0, zero_in = 1, tw_addr 0,1,2,3, out_valid = 4 pulses; then IDLE.
- Stall: in_valid low for 3 cycles at cnt == 5 -> cnt holds at 5, sr_en = 0, no out_valid; resumes at bf_sel = 1.
- Resync: in_sof at cnt == 2 in RUN -> sof_err one pulse, next cnt = 1, state FILL, out_valid low for next 3 advances.
- Pending flush: flush at cnt == 6 -> accepts samples 6,7, then FLUSH 4 cycles. Repeat with STAGE=1 (DELAY=2) -> tw_addr 0,2.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fft_pkg                                                                     |
// | Shared state encoding and parameter derivations for SDF stage controllers.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  function automatic int fft_log2n(input int n);
    return $clog2(n);
  endfunction

  // Stage s of a radix-2 SDF pipeline delays by N/2, N/4, ... samples.
  function automatic int fft_delay(input int n, input int stage);
    return n >> (stage + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdf_stage_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sdf_stage_ctrl                                                              |
// | Sequencer for one radix-2 single-path delay-feedback FFT stage.             |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter  int N_FFT = 64,
  parameter  int STAGE = 0,
  localparam int LOG2N = fft_log2n(N_FFT),
  localparam int DELAY = fft_delay(N_FFT, STAGE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             flush,
  output logic             in_ready,
  output logic             sr_en,
  output logic             zero_in,
  output logic             bf_sel,
  output logic [LOG2N-2:0] tw_addr,
  output logic             tw_en,
  output logic             out_valid,
  output logic             out_sof,
  output logic             sof_err,
  output logic             busy
);

  localparam int CNT_W = LOG2N - STAGE;

  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_delay      = CNT_W'(DELAY);
  localparam logic [CNT_W-1:0] c_last       = CNT_W'(2 * DELAY - 1);
  localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(DELAY - 1);
  localparam logic [LOG2N-1:0] c_k_mask     = LOG2N'(DELAY - 1);
  // With a single-sample delay line the first sample already completes the fill.
  localparam state_t           c_sof_state  = (DELAY == 1) ? ST_RUN : ST_FILL;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flush_pend;

  logic             w_acc;
  logic             w_adv;
  logic             w_phase;
  logic             w_cnt_zero;
  logic             w_wrap;
  logic             w_resync;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [LOG2N-1:0] w_k;

  assign in_ready   = (r_state != ST_FLUSH);
  assign w_acc      = in_valid & in_ready;
  assign w_adv      = (w_acc & ((r_state != ST_IDLE) | in_sof)) | (r_state == ST_FLUSH);
  assign w_phase    = r_cnt[CNT_W-1];
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_inc  = r_cnt + c_one;
  assign w_wrap     = (r_cnt == c_last);
  assign w_resync   = w_acc & in_sof & ~w_cnt_zero &
                      ((r_state == ST_FILL) | (r_state == ST_RUN));
  assign w_k        = LOG2N'(r_cnt) & c_k_mask;

  assign sr_en   = w_adv;
  assign zero_in = (r_state == ST_FLUSH);
  assign bf_sel  = w_phase;
  assign tw_en   = w_adv & ~w_phase & (r_state != ST_FILL);
  assign tw_addr = (LOG2N-1)'(w_k << STAGE);
  assign busy    = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      out_valid    <= 1'b0;
      out_sof      <= 1'b0;
      sof_err      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      sof_err   <= w_resync;
      case (r_state)
        ST_IDLE: begin
          if (w_adv) begin
            r_state <= c_sof_state;
            r_cnt   <= c_one;
          end
        end
        ST_FILL: begin
          // A flush during fill abandons the partial frame without draining.
          if (flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_resync) begin
            r_state <= c_sof_state;
            r_cnt   <= c_one;
          end else if (w_adv) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == c_delay) begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_resync) begin
            r_state      <= c_sof_state;
            r_cnt        <= c_one;
            r_flush_pend <= 1'b0;
          end else if (w_adv) begin
            r_cnt     <= w_cnt_inc;
            out_valid <= 1'b1;
            out_sof   <= (r_cnt == c_delay);
            if (w_wrap && (r_flush_pend || flush)) begin
              r_state      <= ST_FLUSH;
              r_flush_pend <= 1'b0;
            end else if (flush) begin
              r_flush_pend <= 1'b1;
            end
          end else if (flush) begin
            if (w_cnt_zero) begin
              r_state      <= ST_FLUSH;
              r_flush_pend <= 1'b0;
            end else begin
              r_flush_pend <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          out_valid <= 1'b1;
          if (r_cnt == c_drain_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdf_stage_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_sdf_stage_ctrl                                                           |
// | Self-checking bench: N_FFT=8 controllers for stage 0 and stage 1.           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_sdf_stage_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_sof;
  logic       flush;
  logic       rdy [2];
  logic       sr  [2];
  logic       zr  [2];
  logic       bf  [2];
  logic [1:0] twa [2];
  logic       twen[2];
  logic       ov  [2];
  logic       os  [2];
  logic       se  [2];
  logic       bsy [2];

  sdf_stage_ctrl #(.N_FFT(8), .STAGE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .flush(flush),
    .in_ready(rdy[0]), .sr_en(sr[0]), .zero_in(zr[0]), .bf_sel(bf[0]),
    .tw_addr(twa[0]), .tw_en(twen[0]), .out_valid(ov[0]), .out_sof(os[0]),
    .sof_err(se[0]), .busy(bsy[0])
  );

  sdf_stage_ctrl #(.N_FFT(8), .STAGE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .flush(flush),
    .in_ready(rdy[1]), .sr_en(sr[1]), .zero_in(zr[1]), .bf_sel(bf[1]),
    .tw_addr(twa[1]), .tw_en(twen[1]), .out_valid(ov[1]), .out_sof(os[1]),
    .sof_err(se[1]), .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: [10] in_ready [9] sr_en [8] zero_in [7] bf_sel
  // [6:5] tw_addr [4] tw_en [3] out_valid [2] out_sof [1] sof_err [0] busy
  localparam logic [10:0] RESET_VEC = 11'b100_0000_0000;

  typedef struct {
    bit          v, s, f;
    logic [10:0] exp;
  } vec_t;

  // Frame-level view of a stage: position in frame, whether the first half
  // is loaded, and how many drain samples remain.
  typedef struct {
    int pos;
    bit active;
    bit primed;
    bit pend;
    int drain;
    bit ov, os, se;
  } mdl_t;

  mdl_t        mdl [2];
  int          dly [2] = '{4, 2};
  int          stg [2] = '{0, 1};
  logic [10:0] last[2];
  vec_t        tbl [$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  function automatic logic [10:0] observe(input int i);
    return {rdy[i], sr[i], zr[i], bf[i], twa[i], twen[i], ov[i], os[i], se[i], bsy[i]};
  endfunction

  function automatic logic [10:0] predict(input int i, input bit v, input bit s);
    bit drn, acc, adv, ph, te;
    int k, ta;
    drn = mdl[i].drain > 0;
    acc = v && !drn;
    adv = drn || (acc && (mdl[i].active || s));
    k   = drn ? dly[i] - mdl[i].drain : mdl[i].pos % dly[i];
    ph  = !drn && (mdl[i].pos >= dly[i]);
    te  = adv && !ph && !(mdl[i].active && !mdl[i].primed);
    ta  = (k * (1 << stg[i])) % 4;
    return {!drn, adv, drn, ph, 2'(ta), te, mdl[i].ov, mdl[i].os, mdl[i].se,
            mdl[i].active || drn};
  endfunction

  function automatic void advance(input int i, input bit v, input bit s, input bit f);
    bit acc;
    int d;
    d   = dly[i];
    acc = v && (mdl[i].drain == 0);
    mdl[i].ov = 1'b0;
    mdl[i].os = 1'b0;
    mdl[i].se = acc && s && mdl[i].active && (mdl[i].pos != 0);
    if (mdl[i].drain > 0) begin
      mdl[i].ov = 1'b1;
      mdl[i].drain--;
    end else if (!mdl[i].active) begin
      if (acc && s) begin
        mdl[i].active = 1'b1;
        mdl[i].pos    = 1;
        mdl[i].primed = (d == 1);
      end
    end else if (!mdl[i].primed) begin
      if (f) begin
        mdl[i].active = 1'b0;
        mdl[i].pos    = 0;
      end else if (acc && s) begin
        mdl[i].pos    = 1;
        mdl[i].primed = (d == 1);
      end else if (acc) begin
        mdl[i].pos++;
        if (mdl[i].pos == d) mdl[i].primed = 1'b1;
      end
    end else begin
      if (acc && s && mdl[i].pos != 0) begin
        mdl[i].pos    = 1;
        mdl[i].primed = (d == 1);
        mdl[i].pend   = 1'b0;
      end else if (acc) begin
        mdl[i].ov  = 1'b1;
        mdl[i].os  = (mdl[i].pos == d);
        mdl[i].pos = (mdl[i].pos + 1) % (2 * d);
        if (mdl[i].pos == 0 && (mdl[i].pend || f)) begin
          mdl[i].drain  = d;
          mdl[i].active = 1'b0;
          mdl[i].pend   = 1'b0;
        end else if (f) begin
          mdl[i].pend = 1'b1;
        end
      end else if (f) begin
        if (mdl[i].pos == 0) begin
          mdl[i].drain  = d;
          mdl[i].active = 1'b0;
          mdl[i].pend   = 1'b0;
        end else begin
          mdl[i].pend = 1'b1;
        end
      end
    end
  endfunction

  function automatic void check_vec(input string name, input logic [10:0] act,
                                    input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic void check_bit(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic vec_t row(input bit v, s, f, rdy_e, sr_e, zr_e, bf_e,
                               input int ta, input bit te, ov_e, os_e, se_e, bsy_e);
    vec_t r;
    r.v   = v;
    r.s   = s;
    r.f   = f;
    r.exp = {rdy_e, sr_e, zr_e, bf_e, 2'(ta), te, ov_e, os_e, se_e, bsy_e};
    return r;
  endfunction

  task automatic step(input bit v, input bit s, input bit f);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    flush    = f;
    #1;
    for (int i = 0; i < 2; i++) begin
      last[i] = observe(i);
      check_vec($sformatf("model cyc%0d dut%0d", cyc, i), last[i], predict(i, v, s));
      advance(i, v, s, f);
    end
    cyc++;
  endtask

  task automatic do_reset(input bit v);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = v;
    in_sof   = 1'b0;
    flush    = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_vec($sformatf("reset dut%0d", i), observe(i), RESET_VEC);
      mdl[i] = '{default: 0};
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit v, s, f;
    int r;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    flush    = 1'b0;

    //          v  s  f  rdy sr zr bf twa te ov os se bsy
    tbl.push_back(row(1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 0, 3, 0, 0, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 1, 2, 0, 1, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 1, 3, 0, 1, 0, 0, 1));
    tbl.push_back(row(1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 0, 2, 1, 1, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 0, 3, 1, 1, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 1, 2, 0, 1, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 1, 1, 0, 1, 3, 0, 1, 0, 0, 1));
    tbl.push_back(row(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 1, 1, 0, 2, 1, 1, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 1, 1, 0, 3, 1, 1, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    do_reset(1'b0);

    // Two frames and a flush at a frame boundary, against fixed expectations.
    foreach (tbl[n]) begin
      step(tbl[n].v, tbl[n].s, tbl[n].f);
      check_vec($sformatf("tbl[%0d]", n), last[0], tbl[n].exp);
    end

    // Stall at cnt 5.
    step(1, 1, 0);
    repeat (4) step(1, 0, 0);
    step(0, 0, 0);
    check_bit("stall sr_en", int'(last[0][9]), 0);
    check_bit("stall tw_addr", int'(last[0][6:5]), 1);
    step(0, 0, 0);
    check_bit("stall out_valid 2", int'(last[0][3]), 0);
    step(0, 0, 0);
    check_bit("stall out_valid 3", int'(last[0][3]), 0);
    check_bit("stall bf_sel", int'(last[0][7]), 1);
    step(1, 0, 0);
    check_bit("resume bf_sel", int'(last[0][7]), 1);
    check_bit("resume sr_en", int'(last[0][9]), 1);
    check_bit("resume out_valid", int'(last[0][3]), 0);
    repeat (2) step(1, 0, 0);

    // Resync: in_sof at cnt 2 of a running frame.
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    check_bit("resync sof_err same cycle", int'(last[0][1]), 0);
    step(1, 0, 0);
    check_bit("resync sof_err pulse", int'(last[0][1]), 1);
    check_bit("resync restart tw_addr", int'(last[0][6:5]), 1);
    check_bit("resync out_valid 0", int'(last[0][3]), 0);
    step(1, 0, 0);
    check_bit("resync sof_err clear", int'(last[0][1]), 0);
    check_bit("resync out_valid 1", int'(last[0][3]), 0);
    step(1, 0, 0);
    check_bit("resync out_valid 2", int'(last[0][3]), 0);
    step(1, 0, 0);
    check_bit("resync out_valid 3", int'(last[0][3]), 0);
    check_bit("resync refill bf_sel", int'(last[0][7]), 1);
    repeat (3) step(1, 0, 0);

    // Pending flush at cnt 6 (stage 1 sees cnt 2).
    step(1, 1, 0);
    repeat (5) step(1, 0, 0);
    step(1, 0, 1);
    check_bit("pend in_ready", int'(last[0][10]), 1);
    step(1, 0, 0);
    check_bit("pend last sample sr_en", int'(last[0][9]), 1);
    step(0, 0, 0);
    check_bit("drain0 in_ready", int'(last[0][10]), 0);
    check_bit("drain0 zero_in", int'(last[0][8]), 1);
    check_bit("drain0 tw_addr s1", int'(last[1][6:5]), 0);
    step(0, 0, 0);
    check_bit("drain1 tw_addr s0", int'(last[0][6:5]), 1);
    check_bit("drain1 tw_addr s1", int'(last[1][6:5]), 2);
    step(0, 0, 0);
    check_bit("drain2 tw_addr s0", int'(last[0][6:5]), 2);
    check_bit("drain done in_ready s1", int'(last[1][10]), 1);
    step(0, 0, 0);
    check_bit("drain3 tw_addr s0", int'(last[0][6:5]), 3);
    step(0, 0, 0);
    check_bit("drain done busy s0", int'(last[0][0]), 0);

    // Reset with a flush pending: the pending flush must be forgotten.
    step(1, 1, 0);
    repeat (5) step(1, 0, 0);
    step(1, 0, 1);
    do_reset(1'b1);
    step(1, 1, 0);
    repeat (7) step(1, 0, 0);
    step(0, 0, 0);
    check_bit("post-reset no drain in_ready", int'(last[0][10]), 1);
    check_bit("post-reset no drain zero_in", int'(last[0][8]), 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 999);
      if (r < 4) begin
        do_reset(1'b1);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 19) == 0) ||
            (mdl[0].pos == 0 && mdl[0].drain == 0 && $urandom_range(0, 1) == 1);
        f = ($urandom_range(0, 29) == 0);
        step(v, s, f);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
